// File: rtl/simd_ld_pkg.sv
// rtl/simd_ld_pkg.sv - mode encodings, derived-width helpers and nibble record for simd_ld_pipe
package simd_ld_pkg;

    localparam int MODE_L8   = 0;
    localparam int MODE_L16  = 1;
    localparam int MODE_L32  = 2;
    localparam int MODE_L64  = 3;
    localparam int MODE_L128 = 4;
    localparam int MODE_L256 = 5;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } nib_t;

    function automatic int slot_count(input int w);
        return w / 8;
    endfunction

    function automatic int mode_count(input int w);
        return $clog2(w / 8) + 1;
    endfunction

    function automatic int mode_width(input int w);
        return (mode_count(w) > 1) ? $clog2(mode_count(w)) : 1;
    endfunction

    function automatic int lane_count(input int w, input int mode);
        return w / (8 << mode);
    endfunction

    // Reduction nodes are stored heap-style: level 0 (nibbles) first, then each coarser level.
    function automatic int lvl_base(input int w, input int lvl);
        return (w / 2) - ((w / 2) >> lvl);
    endfunction

endpackage

// File: rtl/ld_nib4.sv
// rtl/ld_nib4.sv - 4-bit leading-one encoder, count is the MSB-relative index of the first one
module ld_nib4
    import simd_ld_pkg::*;
(
    input  logic [3:0] nib_i,
    output nib_t       enc_o
);

    always_comb begin
        enc_o       = '0;
        enc_o.valid = |nib_i;
        if (nib_i[3]) begin
            enc_o.cnt = 2'd0;
        end else if (nib_i[2]) begin
            enc_o.cnt = 2'd1;
        end else if (nib_i[1]) begin
            enc_o.cnt = 2'd2;
        end else if (nib_i[0]) begin
            enc_o.cnt = 2'd3;
        end
    end

endmodule

// File: rtl/simd_ld_pipe.sv
// rtl/simd_ld_pipe.sv - two-stage SIMD regime leading-bit detector with valid/ready flow control
module simd_ld_pipe
    import simd_ld_pkg::*;
#(
    parameter  int W  = 32,
    localparam int NL = slot_count(W),
    localparam int CW = $clog2(W),
    localparam int NM = mode_count(W),
    localparam int MW = mode_width(W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [W-1:0]       in_data_i,
    input  logic [MW-1:0]      in_mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [NL*CW-1:0]   out_count_o,
    output logic [NL-1:0]      out_valid_lane_o,
    output logic               out_mode_err_o
);

    localparam int NN0 = W / 4;
    localparam int NND = W / 2 - 1;

    logic [W-1:0]      x_mode [NM];
    logic [W-1:0]      in_x;
    logic              in_err;
    nib_t [NN0-1:0]    nib_enc;

    logic              s2_en, s1_en, s1_ld, out_ld;

    logic              s1_v_q, s1_v_d;
    logic [W-1:0]      s1_x_q, s1_x_d;
    logic [MW-1:0]     s1_mode_q, s1_mode_d;
    logic              s1_err_q, s1_err_d;
    nib_t [NN0-1:0]    s1_nib_q, s1_nib_d;

    logic [CW-1:0]     nd_cnt [NND];
    logic [NND-1:0]    nd_v;
    logic [NL*CW-1:0]  sel_cnt;
    logic [NL-1:0]     sel_lv;

    logic              out_valid_q, out_valid_d;
    logic [NL*CW-1:0]  out_count_q, out_count_d;
    logic [NL-1:0]     out_lv_q, out_lv_d;
    logic              out_err_q, out_err_d;

    // Lane sign bits never reach the detector, and x is kept only as staged state.
    logic              unused_bits;
    assign unused_bits = ^{in_data_i[W-1], s1_x_q};

    // Per-mode regime preprocessing: invert on the control bit, clear the sign bit.
    for (genvar m = 0; m < NM; m++) begin : g_inv
        localparam int LW = 8 << m;
        logic [W-1:0] xv;
        for (genvar k = 0; k < lane_count(W, m); k++) begin : g_lane
            assign xv[k*LW +: LW] = {1'b0, in_data_i[k*LW +: LW-1] ^ {(LW-1){in_data_i[k*LW+LW-2]}}};
        end
        assign x_mode[m] = xv;
    end

    always_comb begin
        in_err = (int'(in_mode_i) >= NM);
        in_x   = '0;
        for (int m = 0; m < NM; m++) begin
            if (in_mode_i == MW'(m)) begin
                in_x = x_mode[m];
            end
        end
    end

    for (genvar i = 0; i < NN0; i++) begin : g_nib
        ld_nib4 u_nib (
            .nib_i (in_x[4*i +: 4]),
            .enc_o (nib_enc[i])
        );
    end

    always_comb begin
        s2_en     = ~out_valid_q | out_ready_i;
        s1_en     = ~s1_v_q | s2_en;
        s1_ld     = s1_en & in_valid_i;
        s1_v_d    = s1_en ? in_valid_i : s1_v_q;
        s1_x_d    = s1_ld ? in_x      : s1_x_q;
        s1_mode_d = s1_ld ? in_mode_i : s1_mode_q;
        s1_err_d  = s1_ld ? in_err    : s1_err_q;
        s1_nib_d  = s1_ld ? nib_enc   : s1_nib_q;
    end

    assign in_ready_o = s1_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_x_q    <= '0;
            s1_mode_q <= '0;
            s1_err_q  <= 1'b0;
            s1_nib_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_x_q    <= s1_x_d;
            s1_mode_q <= s1_mode_d;
            s1_err_q  <= s1_err_d;
            s1_nib_q  <= s1_nib_d;
        end
    end

    // Pairwise merge: the upper half wins if valid, else the lower count is offset by the half width.
    always_comb begin
        nd_cnt = '{default: '0};
        nd_v   = '0;
        for (int i = 0; i < NN0; i++) begin
            nd_cnt[i] = CW'(s1_nib_q[i].cnt);
            nd_v[i]   = s1_nib_q[i].valid;
        end
        for (int j = 1; j <= NM; j++) begin
            for (int i = 0; i < NN0 / 2; i++) begin
                if (i < (NN0 >> j)) begin
                    if (nd_v[lvl_base(W, j-1) + 2*i + 1]) begin
                        nd_cnt[lvl_base(W, j) + i] = nd_cnt[lvl_base(W, j-1) + 2*i + 1];
                    end else if (nd_v[lvl_base(W, j-1) + 2*i]) begin
                        nd_cnt[lvl_base(W, j) + i] = nd_cnt[lvl_base(W, j-1) + 2*i]
                                                     | CW'(32'd4 << (j - 1));
                    end
                    nd_v[lvl_base(W, j) + i] = nd_v[lvl_base(W, j-1) + 2*i + 1]
                                              | nd_v[lvl_base(W, j-1) + 2*i];
                end
            end
        end
    end

    // Mode m reads tree level m+1 (nodes of width 8<<m); an illegal mode matches nothing.
    always_comb begin
        sel_cnt = '0;
        sel_lv  = '0;
        for (int m = 0; m < NM; m++) begin
            if (!s1_err_q && s1_mode_q == MW'(m)) begin
                for (int k = 0; k < NL; k++) begin
                    if (k < (NL >> m)) begin
                        sel_cnt[k*CW +: CW] = nd_cnt[lvl_base(W, m+1) + k];
                        sel_lv[k]           = nd_v[lvl_base(W, m+1) + k];
                    end
                end
            end
        end
    end

    always_comb begin
        out_ld      = s2_en & s1_v_q;
        out_valid_d = s2_en ? s1_v_q : out_valid_q;
        out_count_d = out_ld ? sel_cnt  : out_count_q;
        out_lv_d    = out_ld ? sel_lv   : out_lv_q;
        out_err_d   = out_ld ? s1_err_q : out_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_lv_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_lv_q    <= out_lv_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_count_o      = out_count_q;
    assign out_valid_lane_o = out_lv_q;
    assign out_mode_err_o   = out_err_q;

endmodule

// File: tb/tb_simd_ld_pipe.sv
// tb/tb_simd_ld_pipe.sv - table-driven and sequence checks for simd_ld_pipe
module tb_simd_ld_pipe;
    import simd_ld_pkg::*;

    localparam int NV = 11;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [19:0] cnt;
        logic [3:0]  lv;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_in_data;
    logic [1:0]  a_in_mode;
    logic [19:0] a_out_count;
    logic [3:0]  a_out_lv;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [63:0] b_in_data;
    logic [1:0]  b_in_mode;
    logic [47:0] b_out_count;
    logic [7:0]  b_out_lv;

    simd_ld_pipe #(.W(32)) u_dut32 (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (a_in_valid),
        .in_ready_o       (a_in_ready),
        .in_data_i        (a_in_data),
        .in_mode_i        (a_in_mode),
        .out_valid_o      (a_out_valid),
        .out_ready_i      (a_out_ready),
        .out_count_o      (a_out_count),
        .out_valid_lane_o (a_out_lv),
        .out_mode_err_o   (a_out_err)
    );

    simd_ld_pipe #(.W(64)) u_dut64 (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (b_in_valid),
        .in_ready_o       (b_in_ready),
        .in_data_i        (b_in_data),
        .in_mode_i        (b_in_mode),
        .out_valid_o      (b_out_valid),
        .out_ready_i      (b_out_ready),
        .out_count_o      (b_out_count),
        .out_valid_lane_o (b_out_lv),
        .out_mode_err_o   (b_out_err)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, "_valid"}, 64'(a_out_valid), 64'd1);
        chk({tag, "_cnt"},   64'(a_out_count), 64'(v.cnt));
        chk({tag, "_lv"},    64'(a_out_lv),    64'(v.lv));
        chk({tag, "_err"},   64'(a_out_err),   64'(v.err));
    endtask

    task automatic drive_a(input vec_t v);
        a_in_valid = 1'b1;
        a_in_mode  = v.mode;
        a_in_data  = v.data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{mode: 2'(MODE_L8),  data: 32'h08F020C0, cnt: {5'd4, 5'd4, 5'd2, 5'd2},  lv: 4'hF, err: 1'b0};
        vecs[1]  = '{mode: 2'(MODE_L32), data: 32'h40000000, cnt: {5'd0, 5'd0, 5'd0, 5'd2},  lv: 4'h1, err: 1'b0};
        vecs[2]  = '{mode: 2'(MODE_L32), data: 32'h7FFFFFFF, cnt: 20'd0,                     lv: 4'h0, err: 1'b0};
        vecs[3]  = '{mode: 2'(MODE_L16), data: 32'h00018000, cnt: {5'd0, 5'd0, 5'd15, 5'd0}, lv: 4'h2, err: 1'b0};
        vecs[4]  = '{mode: 2'd3,         data: 32'hDEADBEEF, cnt: 20'd0,                     lv: 4'h0, err: 1'b1};
        vecs[5]  = '{mode: 2'(MODE_L8),  data: 32'h00000000, cnt: 20'd0,                     lv: 4'h0, err: 1'b0};
        vecs[6]  = '{mode: 2'(MODE_L8),  data: 32'h7F41013F, cnt: {5'd0, 5'd2, 5'd7, 5'd2},  lv: 4'h7, err: 1'b0};
        vecs[7]  = '{mode: 2'(MODE_L16), data: 32'hC0000100, cnt: {5'd0, 5'd0, 5'd2, 5'd7},  lv: 4'h3, err: 1'b0};
        vecs[8]  = '{mode: 2'(MODE_L32), data: 32'h00000001, cnt: {5'd0, 5'd0, 5'd0, 5'd31}, lv: 4'h1, err: 1'b0};
        vecs[9]  = '{mode: 2'(MODE_L32), data: 32'hFFFF0000, cnt: {5'd0, 5'd0, 5'd0, 5'd16}, lv: 4'h1, err: 1'b0};
        vecs[10] = '{mode: 2'(MODE_L8),  data: 32'h80FF4001, cnt: {5'd0, 5'd0, 5'd2, 5'd7},  lv: 4'h3, err: 1'b0};

        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_in_mode   = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_mode   = '0;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_count", 64'(a_out_count), 64'd0);
        chk("rst_out_lv",    64'(a_out_lv),    64'd0);
        chk("rst_out_err",   64'(a_out_err),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_idle",      64'(a_out_valid), 64'd0);

        // Back-to-back stream; each result is checked two edges after it was driven.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive_a(vecs[i]);
            else a_in_valid = 1'b0;
            @(negedge clk);
            if (i == 0) chk("lat_not_early", 64'(a_out_valid), 64'd0);
            else chk_out($sformatf("vec%0d", i - 1), vecs[i-1]);
        end
        @(negedge clk);
        chk("drain_valid", 64'(a_out_valid), 64'd0);

        // Stall: A and B fill both stages, C waits until the output drains.
        a_out_ready = 1'b0;
        drive_a(vecs[0]);
        @(negedge clk);
        chk("stall_rdy_b", 64'(a_in_ready), 64'd1);
        drive_a(vecs[6]);
        @(negedge clk);
        drive_a(vecs[10]);
        #1;
        chk("stall_rdy_c", 64'(a_in_ready), 64'd0);
        chk_out("stall_a0", vecs[0]);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("stall_rdy_hold%0d", c), 64'(a_in_ready), 64'd0);
            chk_out($sformatf("stall_hold%0d", c), vecs[0]);
        end
        a_out_ready = 1'b1;
        #1;
        chk("stall_rdy_release", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk_out("stall_b", vecs[6]);
        @(negedge clk);
        chk_out("stall_c", vecs[10]);
        @(negedge clk);
        chk("stall_drain", 64'(a_out_valid), 64'd0);

        // Reset with two beats in flight in both instances.
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        drive_a(vecs[0]);
        b_in_valid = 1'b1;
        b_in_mode  = 2'd0;
        b_in_data  = 64'h0102030405060708;
        @(negedge clk);
        drive_a(vecs[6]);
        b_in_data  = 64'h1111111111111111;
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk("inflight_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", 64'(a_out_valid), 64'd0);
        chk("rst_async_b", 64'(b_out_valid), 64'd0);
        chk("rst_async_cnt", 64'(a_out_count), 64'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("no_stale_a%0d", c), 64'(a_out_valid), 64'd0);
            chk($sformatf("no_stale_b%0d", c), 64'(b_out_valid), 64'd0);
        end
        b_in_valid = 1'b1;
        b_in_mode  = 2'(MODE_L64);
        b_in_data  = 64'h4000000000000000;
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("w64_valid", 64'(b_out_valid), 64'd1);
        chk("w64_cnt",   64'(b_out_count), 64'd2);
        chk("w64_lv",    64'(b_out_lv),    64'h01);
        chk("w64_err",   64'(b_out_err),   64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
